// File: rtl/load_store_unit.sv
// Load/store unit: one data-memory transaction per request over a req/gnt/rvalid bus,
// with byte-enable generation, lane replication, load extension and error flagging.
module load_store_unit #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned XLEN  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [2:0]        lat_f3, lat_f3_nx;
    logic [1:0]        lat_off, lat_off_nx;
    logic              busy_nx, done_nx, mis_nx, berr_nx;
    logic              mem_req_nx, mem_we_nx;
    logic [XLEN-1:0]   mem_addr_nx, mem_wdata_nx, rdata_nx;
    logic [3:0]        mem_be_nx;

    logic              req_bad;
    logic [3:0]        be_c;
    logic [XLEN-1:0]   wd_c;
    logic [XLEN-1:0]   lane;
    logic [XLEN-1:0]   load_c;

    // Request legality: illegal encodings and size-misaligned addresses
    always_comb begin
        req_bad = 1'b0;
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111)
            req_bad = 1'b1;
        if (is_store && funct3[2])
            req_bad = 1'b1;
        if (funct3[1:0] == 2'b01 && addr[0])
            req_bad = 1'b1;
        if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00)
            req_bad = 1'b1;
    end

    // Byte enables and lane-replicated store data for the incoming request
    always_comb begin
        be_c = 4'b1111;
        wd_c = wdata;
        unique case (funct3[1:0])
            2'b00: begin
                be_c = 4'b0001 << addr[1:0];
                wd_c = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_c = 4'b0011 << addr[1:0];
                wd_c = {2{wdata[15:0]}};
            end
            default: begin
                be_c = 4'b1111;
                wd_c = wdata;
            end
        endcase
    end

    // Lane select and sign/zero extension of the returned word
    always_comb begin
        lane = mem_rdata >> {lat_off, 3'b000};
        unique case (lat_f3)
            3'b000:  load_c = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_c = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_c = {24'd0, lane[7:0]};
            3'b101:  load_c = {16'd0, lane[15:0]};
            default: load_c = lane;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        lat_f3_nx    = lat_f3;
        lat_off_nx   = lat_off;
        done_nx      = 1'b0;
        mis_nx       = 1'b0;
        berr_nx      = 1'b0;
        mem_req_nx   = mem_req;
        mem_we_nx    = mem_we;
        mem_addr_nx  = mem_addr;
        mem_be_nx    = mem_be;
        mem_wdata_nx = mem_wdata;
        rdata_nx     = rdata;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (req_bad) begin
                        done_nx = 1'b1;
                        mis_nx  = 1'b1;
                    end else begin
                        state_nx     = REQ;
                        cnt_nx       = '0;
                        lat_f3_nx    = funct3;
                        lat_off_nx   = addr[1:0];
                        mem_req_nx   = 1'b1;
                        mem_we_nx    = is_store;
                        mem_addr_nx  = {addr[31:2], 2'b00};
                        mem_be_nx    = be_c;
                        mem_wdata_nx = wd_c;
                    end
                end
            end
            REQ, RESP: begin
                if (state == REQ && mem_gnt && mem_we) begin
                    state_nx   = IDLE;
                    mem_req_nx = 1'b0;
                    done_nx    = 1'b1;
                end else if (state == RESP && mem_rvalid) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                    rdata_nx = load_c;
                end else if (cnt == CNT_W'(MAX_WAIT - 1)) begin
                    state_nx   = IDLE;
                    mem_req_nx = 1'b0;
                    done_nx    = 1'b1;
                    berr_nx    = 1'b1;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                    if (state == REQ && mem_gnt) begin
                        state_nx   = RESP;
                        mem_req_nx = 1'b0;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        busy_nx = (state_nx != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            lat_f3     <= '0;
            lat_off    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            rdata      <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            lat_f3     <= lat_f3_nx;
            lat_off    <= lat_off_nx;
            busy       <= busy_nx;
            done       <= done_nx;
            misaligned <= mis_nx;
            bus_err    <= berr_nx;
            mem_req    <= mem_req_nx;
            mem_we     <= mem_we_nx;
            mem_addr   <= mem_addr_nx;
            mem_be     <= mem_be_nx;
            mem_wdata  <= mem_wdata_nx;
            rdata      <= rdata_nx;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a scoreboard of expected completions.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy, done, misaligned, bus_err;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    typedef struct {
        logic [31:0] rd;
        logic        mis;
        logic        berr;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          t0;
    logic [31:0] last_rd = 32'd0;

    load_store_unit #(.MAX_WAIT(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store),
        .funct3(funct3), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
        .rdata(rdata), .misaligned(misaligned), .bus_err(bus_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for done, then compares against the oldest scoreboard entry
    task automatic expect_done(input string tag);
        exp_t e;
        int   waited = 0;
        while (done !== 1'b1 && waited < 12) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        e = sb.pop_front();
        check({tag, "_lat"}, 32'(cyc - t0), 32'(e.lat));
        check({tag, "_rdata"}, rdata, e.rd);
        check({tag, "_mis"}, 32'(misaligned), 32'(e.mis));
        check({tag, "_berr"}, 32'(bus_err), 32'(e.berr));
        @(negedge clk);
        check({tag, "_pulse"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic run_txn(input string tag, input logic st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int gs, input int rs, input logic [31:0] mrd,
                           input logic mis, input logic [31:0] xrd,
                           input logic [31:0] xaddr, input logic [3:0] xbe,
                           input logic [31:0] xwd);
        exp_t e;
        e.mis  = mis;
        e.berr = 1'b0;
        e.lat  = mis ? 1 : (st ? 2 + gs : 3 + gs + rs);
        if (!mis && !st) last_rd = xrd;
        e.rd = last_rd;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        if (mis) begin
            check({tag, "_noreq"}, 32'(mem_req), 32'd0);
            check({tag, "_nobusy"}, 32'(busy), 32'd0);
        end else begin
            check({tag, "_req"}, 32'(mem_req), 32'd1);
            check({tag, "_busy"}, 32'(busy), 32'd1);
            for (int i = 0; i <= gs; i++) begin
                if (i > 0) @(negedge clk);
                check({tag, "_reqhold"}, 32'(mem_req), 32'd1);
                check({tag, "_addr"}, mem_addr, xaddr);
                check({tag, "_be"}, 32'(mem_be), 32'(xbe));
                check({tag, "_we"}, 32'(mem_we), 32'(st));
                if (st) check({tag, "_wdata"}, mem_wdata, xwd);
            end
            mem_gnt = 1'b1;
            @(negedge clk);
            mem_gnt = 1'b0;
            check({tag, "_reqdrop"}, 32'(mem_req), 32'd0);
            if (!st) begin
                repeat (rs) @(negedge clk);
                mem_rvalid = 1'b1;
                mem_rdata  = mrd;
                @(negedge clk);
                mem_rvalid = 1'b0;
                mem_rdata  = 32'h0;
            end
        end
        expect_done(tag);
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b0; start = 1'b0; is_store = 1'b0; funct3 = 3'b000;
        addr = '0; wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rst_n = 1'b1;

        run_txn("lw", 1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 32'h100, 4'b1111, 32'h0);
        run_txn("lb", 1'b0, 3'b000, 32'h103, 32'h0, 0, 0, 32'h80123456, 1'b0, 32'hFFFFFF80, 32'h100, 4'b1000, 32'h0);
        run_txn("lbu", 1'b0, 3'b100, 32'h103, 32'h0, 0, 1, 32'h80123456, 1'b0, 32'h00000080, 32'h100, 4'b1000, 32'h0);
        run_txn("lhu", 1'b0, 3'b101, 32'h102, 32'h0, 1, 0, 32'h80123456, 1'b0, 32'h00008012, 32'h100, 4'b1100, 32'h0);
        run_txn("lh", 1'b0, 3'b001, 32'h100, 32'h0, 0, 0, 32'h0000F00D, 1'b0, 32'hFFFFF00D, 32'h100, 4'b0011, 32'h0);
        run_txn("sh", 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 3, 0, 32'h0, 1'b0, 32'h0, 32'h200, 4'b1100, 32'hABCDABCD);
        run_txn("sb", 1'b1, 3'b000, 32'h001, 32'h000000A5, 0, 0, 32'h0, 1'b0, 32'h0, 32'h000, 4'b0010, 32'hA5A5A5A5);
        run_txn("lw_mis", 1'b0, 3'b010, 32'h101, 32'h0, 0, 0, 32'h0, 1'b1, 32'h0, 32'h0, 4'b0, 32'h0);
        run_txn("sb_ill", 1'b1, 3'b100, 32'h200, 32'h0, 0, 0, 32'h0, 1'b1, 32'h0, 32'h0, 4'b0, 32'h0);
        run_txn("lh_mis", 1'b0, 3'b001, 32'h103, 32'h0, 0, 0, 32'h0, 1'b1, 32'h0, 32'h0, 4'b0, 32'h0);

        // Timeout: grant never arrives
        e.rd = last_rd; e.mis = 1'b0; e.berr = 1'b1; e.lat = 9;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h300;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            check("to_req", 32'(mem_req), 32'd1);
            check("to_nodone", 32'(done), 32'd0);
        end
        @(negedge clk);
        check("to_reqdrop", 32'(mem_req), 32'd0);
        expect_done("to");
        mem_rvalid = 1'b1; mem_rdata = 32'h11111111;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("late_rv_done", 32'(done), 32'd0);
        @(negedge clk);
        check("late_rv_done2", 32'(done), 32'd0);
        check("late_rv_rdata", rdata, last_rd);

        // Reset while waiting for rvalid
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h400;
        @(negedge clk);
        start = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        check("resp_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_req", 32'(mem_req), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h22222222;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("rst_mid_nodone", 32'(done), 32'd0);
        check("rst_mid_rdata", rdata, 32'd0);
        last_rd = 32'd0;

        run_txn("lw_post", 1'b0, 3'b010, 32'h104, 32'h0, 0, 0, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 32'h104, 4'b1111, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Execute-to-memory stage of the single-cycle core. Takes the ALU result as the effective address, plus rs2 and funct3, and runs one data-memory transaction over a req/gnt/rvalid bus. It generates byte enables and replicated write data, and returns sign- or zero-extended load data. It also flags misaligned or illegal accesses and bus timeouts.

## Interface
- MAX_WAIT, 255: cycles allowed in REQ+RESP before a bus error; legal range 2..255.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- is_store  in  1  1 = store, 0 = load.
- funct3  in  3  load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store: 000 SB, 001 SH, 010 SW.
- addr  in  32  effective address (ALU Result).
- wdata  in  32  store data (rs2).
- busy  out  1  state != IDLE.
- done  out  1  one-cycle completion pulse, registered.
- rdata  out  32  extended load data; updated only on successful load done; otherwise held.
- misaligned  out  1  valid with done; misaligned or illegal funct3.
- bus_err  out  1  valid with done; timeout.
- mem_req  out  1  bus request.
- mem_we  out  1  write strobe (= latched is_store).
- mem_addr  out  32  {addr[31:2],2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid this cycle.
- mem_rdata  in  32  read word.

## Operation
- States:
  - IDLE: no transaction.
  - REQ: mem_req=1 until gnt.
  - RESP: waiting for rvalid; loads only.
- Error check (IDLE, start=1):
  - Illegal funct3: 011, 110, 111, or a store with funct3[2]=1.
  - Half-word access (LH/LHU/SH) with addr[0]=1.
  - Word access (LW/SW) with addr[1:0]!=0.
  - On error: no bus activity; next cycle done=1, misaligned=1; stay IDLE.
- Accepted request: latch is_store, funct3, addr, wdata; go to REQ.
- Bus outputs:
  - Byte enables: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111. Loads drive the same pattern.
  - mem_wdata: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
  - mem_addr, mem_be, mem_we, mem_wdata are registered and stable while mem_req=1.
- REQ with mem_gnt=1:
  - Store: done next cycle, go to IDLE, mem_req drops.
  - Load: go to RESP, mem_req drops.
- RESP with mem_rvalid=1:
  - Select lane by addr[1:0].
  - Sign-extend LB/LH; zero-extend LBU/LHU.
  - Write rdata; done next cycle; go to IDLE.
- Timeout:
  - Counter cleared on entry to REQ; increments each REQ/RESP cycle without completion.
  - After MAX_WAIT such cycles: done=1, bus_err=1, mem_req=0, go to IDLE; rdata unchanged.
- mem_rvalid or mem_gnt outside the expected state is ignored.
- start while busy is ignored. start in the cycle done is high is accepted, since the state is already IDLE.
- misaligned and bus_err are 0 whenever done=0.

## Timing
- Reset (async, immediate): state IDLE; counter 0; busy, done, misaligned, bus_err, mem_req, mem_we 0; mem_addr, mem_be, mem_wdata, rdata 0.
- Reset mid-transaction: mem_req drops immediately; no done pulse; any pending response is discarded.
- start accepted at edge T: mem_req=1 and busy=1 from T+1.
- Store, gnt at T+1: done at T+2.
- Load, gnt at T+1, rvalid at T+2: done and rdata at T+3.
- Each gnt-stall cycle and each rvalid-stall cycle adds 1 cycle.
- Error at T: done at T+1; busy never asserts.
- Timeout, MAX_WAIT=N: REQ/RESP occupy T+1..T+N; done+bus_err at T+N+1.
- Throughput: one transaction per 2 cycles (store, immediate gnt, back-to-back start).

## Test plan
- LW addr=0x100, gnt at T+1, rvalid at T+2 with mem_rdata=0xDEADBEEF -> mem_addr=0x100, mem_be=1111, mem_we=0, done at T+3, rdata=0xDEADBEEF.
- LB addr=0x103 with mem_rdata=0x80123456 -> rdata=0xFFFFFF80. LBU same stimulus -> rdata=0x00000080. LHU addr=0x102 -> rdata=0x00008012.
- SH addr=0x202, wdata=0x1234ABCD, gnt held low 3 cycles -> mem_addr=0x200, mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1; all four stable during the stall; done at T+5; rdata unchanged.
- LW addr=0x101, then SB with funct3=100 -> each: no mem_req, done+misaligned at T+1, busy=0.
- MAX_WAIT=8, gnt never asserted -> mem_req high T+1..T+8, done+bus_err at T+9; a later rvalid is ignored (no done).
- rst_n low for one cycle during RESP -> mem_req=0, busy=0, no done. A following LW completes normally with done at T+3.
